// File: rtl/npu_host_if.sv
// Host-side front end for the npu: forwards host words onto the shared tri-state bus,
// parses the 6-word config header to size the job, then drains output activations.
module npu_host_if #(
   parameter int DW        = 32,
   parameter int TO_CYCLES = 65535,
   parameter int CNT_W     = 13
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   inout  wire  [DW-1:0] npu_data,
   output logic          npu_we,
   output logic          npu_oe,
   input  logic          npu_ready,
   output logic          busy,
   output logic          err
);

   localparam int TW = $clog2(TO_CYCLES + 1);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAY, S_WAIT, S_RD, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [DW-1:0]    wdata_q, wdata_d;
   logic             we_q, we_d;
   logic [1:0]       layers_q, layers_d;
   logic [3:0][4:0]  code_q, code_d;
   logic [2:0]       hcnt_q, hcnt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TW-1:0]    tcnt_q, tcnt_d;
   logic [5:0]       rcnt_q, rcnt_d;
   logic [DW-1:0]    out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             err_q, err_d;
   logic             in_hs;
   logic             timeout;
   logic [1:0]       code_idx;

   // Payload words following the header: weights+bias for each layer pair, plus the n0 inputs.
   function automatic logic [CNT_W-1:0] job_payload(input logic [1:0] layers,
                                                     input logic [3:0][4:0] code);
      logic [CNT_W-1:0] n0, n1, n2, n3;
      n0 = CNT_W'(code[0]) + ONE;
      n1 = CNT_W'(code[1]) + ONE;
      n2 = CNT_W'(code[2]) + ONE;
      n3 = CNT_W'(code[3]) + ONE;
      case (layers)
         2'd0:    job_payload = (n0 + ONE) * n3 + n0;
         2'd1:    job_payload = (n0 + ONE) * n1 + (n1 + ONE) * n3 + n0;
         default: job_payload = (n0 + ONE) * n1 + (n1 + ONE) * n2 + (n2 + ONE) * n3 + n0;
      endcase
   endfunction

   assign in_hs    = in_valid & in_ready;
   assign timeout  = (tcnt_q == TW'(TO_CYCLES - 1));
   assign code_idx = hcnt_q[1:0] - 2'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (in_hs && in_data[1:0] != 2'd3) state_d = S_HDR;
         S_HDR:  if (in_hs && hcnt_q == 3'd5) state_d = S_PAY;
         S_PAY:  if (in_hs && cnt_q == ONE) state_d = S_WAIT;
         S_WAIT: begin
            if (npu_ready)    state_d = S_RD;
            else if (timeout) state_d = S_IDLE;
         end
         S_RD:   if (npu_oe && rcnt_q == 6'd1) state_d = S_DONE;
         S_DONE: if (out_valid_q && out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      npu_oe   = 1'b0;
      busy     = (state_q != S_IDLE);
      case (state_q)
         S_IDLE, S_HDR, S_PAY: in_ready = ~rst;
         S_RD:                 npu_oe   = ~out_valid_q | out_ready;
         default: ;
      endcase
   end

   always_comb begin
      wdata_d     = in_hs ? in_data : wdata_q;
      we_d        = in_hs;
      layers_d    = layers_q;
      code_d      = code_q;
      hcnt_d      = hcnt_q;
      cnt_d       = cnt_q;
      tcnt_d      = '0;
      rcnt_d      = rcnt_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      err_d       = err_q;

      // A capture in the same cycle as a host pop simply reloads the register.
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      if (npu_oe) begin
         out_data_d  = npu_data;
         out_valid_d = 1'b1;
         rcnt_d      = rcnt_q - 6'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (in_hs) begin
               layers_d = in_data[1:0];
               hcnt_d   = 3'd1;
               err_d    = (in_data[1:0] == 2'd3);
            end
         end
         S_HDR: begin
            // The npu samples the bus every cycle while loading, so a bubble corrupts it.
            if (!in_valid) err_d = 1'b1;
            if (in_hs) begin
               hcnt_d = hcnt_q + 3'd1;
               if (hcnt_q == 3'd5) cnt_d = job_payload(layers_q, code_q);
               else                code_d[code_idx] = in_data[4:0];
            end
         end
         S_PAY: begin
            if (!in_valid) err_d = 1'b1;
            if (in_hs) cnt_d = cnt_q - ONE;
         end
         S_WAIT: begin
            tcnt_d = tcnt_q + TW'(1);
            if (npu_ready)    rcnt_d = 6'(code_q[3]) + 6'd1;
            else if (timeout) err_d  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q        <= 1'b0;
         layers_q    <= '0;
         code_q      <= '0;
         hcnt_q      <= '0;
         cnt_q       <= '0;
         tcnt_q      <= '0;
         rcnt_q      <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         we_q        <= we_d;
         layers_q    <= layers_d;
         code_q      <= code_d;
         hcnt_q      <= hcnt_d;
         cnt_q       <= cnt_d;
         tcnt_q      <= tcnt_d;
         rcnt_q      <= rcnt_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      wdata_q <= wdata_d;
   end

   // The bus is released as soon as we_q drops, including on an asynchronous reset.
   assign npu_data  = we_q ? wdata_q : {DW{1'bz}};
   assign npu_we    = we_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign err       = err_q;

endmodule

// File: doc/npu_host_if.md
Name: npu_host_if

Overview:
- Host-side front end sitting directly upstream of the npu array-processor top.
- Converts a host valid/ready word stream into the npu's shared tri-state bus protocol (we, data), then waits for npu ready and drains output activations back to the host over a valid/ready stream.
- Parses the 6-word configuration header itself, so it knows the exact job length and needs no sideband length from the host.

Parameters:
- DW, 32, bus/stream word width.
- TO_CYCLES, 65535, maximum cycles to wait for npu_ready after the last word is driven.
- CNT_W, 13, width of the job word counter (max job 6+3168+32=3206 words).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_data  in  DW  host word
- in_valid  in  1  host word valid
- in_ready  out  1  block accepts word
- out_data  out  DW  output activation
- out_valid  out  1  output word valid
- out_ready  in  1  host accepts output
- npu_data  inout  DW  shared npu bus; driven only when npu_we=1, else high-Z
- npu_we  out  1  bus write strobe to npu
- npu_oe  out  1  read strobe to npu
- npu_ready  in  1  npu output-phase indicator
- busy  out  1  job in progress (state != IDLE)
- err  out  1  sticky error; cleared by rst or by acceptance of a new header word 0

Behaviour:
- Reset: in_ready=0, out_valid=0, out_data=0, npu_we=0, npu_oe=0, npu_data=Z, busy=0, err=0, state=IDLE, all counters 0.
- Write path: an accepted word (in_valid&in_ready) is registered and driven onto npu_data with npu_we=1 in the following cycle. Latency is 1 cycle. At most one word per cycle. npu_we=0 and bus high-Z in every other cycle.
- Header decode, header word k counted from 0:
  - w0[1:0] = L, the number of hidden layers.
  - w1..w4[4:0] = neuron codes c0..c3; neuron count n = c+1.
  - w5 = activation mask, passed through only.
- Layer chain:
  - L=0: c0 to c3.
  - L=1: c0 to c1 to c3.
  - L=2: c0 to c1 to c2 to c3.
- Payload length: P = sum over layer pairs (n_in+1)*n_out, plus n0 input words. Computed from registered codes during w5 acceptance and ready before the first payload word. Uses CNT_W-bit unsigned arithmetic with no overflow by construction.
- States:
  - IDLE: in_ready=1. First handshake goes to HDR with word count 1.
  - HDR: in_ready=1. After w5 is accepted, go to PAY with cnt=P.
  - PAY: in_ready=1. cnt decrements per handshake; at cnt==1 with a handshake, go to WAIT.
  - WAIT: in_ready=0, timeout counter runs. npu_ready=1 goes to RD with rcnt=n3. If TO_CYCLES elapse first: err=1, go to IDLE.
  - RD: in_ready=0, bus high-Z. npu_oe=1 in a cycle iff the output register is empty or out_ready=1. The word on npu_data in that cycle is captured into out_data, and out_valid=1 next cycle. rcnt decrements per npu_oe cycle. After the last capture, go to DONE.
  - DONE: hold until the final out_valid&out_ready, then go to IDLE.
- out_valid/out_data hold stable while out_valid&!out_ready.
- Header error: if L==3 when w0 is accepted, set err, stay in IDLE, and treat the next word as a new w0.
- Underrun: the npu samples every cycle in its config/load phases, so a cycle in HDR or PAY with in_valid=0 after w0 sets err. The job continues; the counters advance only on handshakes.
- npu_ready deasserting during RD: ignored; rcnt governs completion.
- Simultaneous output capture and host pop in the same cycle: the register reloads; out_valid stays 1.
- Reset mid-job: immediate return to reset values. Bus is released asynchronously.

Test Plan:
- L=0, c0=1, c3=0 (2 in, 1 out). Send 11 words back-to-back → 11 npu_we cycles, each 1 cycle after accept. WAIT entered after word 11. npu_ready → one npu_oe; out_data equals the bus value 0x3F800000.
- L=1, c0=2, c1=3, c3=1. P=16+10+3=29, total 35 words → in_ready drops exactly after word 35. Two outputs are read in order.
- Backpressure: hold out_ready=0 in RD with 4 outputs → npu_oe issues only 1 word then stalls. out_data stays stable. Releasing out_ready yields the remaining 3 words, one per cycle.
- Header w0=3 → err=1, busy=0. Next valid header accepted normally and err clears on its w0.
- Timeout: complete the job, keep npu_ready=0 for TO_CYCLES → err=1, state IDLE, npu_oe never asserted.
- Insert an in_valid=0 gap at payload word 4 → err=1, job completes after all words are received. Also assert rst mid-PAY → npu_data=Z, npu_we=0, busy=0 the same cycle.
